// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control sequencer: state encoding,
// opcode values, op classes and Rin/Rout index map.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT
    } op_class_e;

    localparam logic [4:0] OP_RTYPE_MAX = 5'b00111;
    localparam logic [4:0] OP_ADDI      = 5'b01000;
    localparam logic [4:0] OP_MUL       = 5'b01111;
    localparam logic [4:0] OP_DIV       = 5'b10000;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    localparam logic [4:0] IDX_HI     = 5'd16;
    localparam logic [4:0] IDX_LO     = 5'd17;
    localparam logic [4:0] IDX_ZHIGH  = 5'd18;
    localparam logic [4:0] IDX_ZLOW   = 5'd19;
    localparam logic [4:0] IDX_PC     = 5'd20;
    localparam logic [4:0] IDX_MDR    = 5'd21;
    localparam logic [4:0] IDX_INPORT = 5'd22;
    localparam logic [4:0] IDX_C      = 5'd23;

    function automatic logic [23:0] onehot(input logic [4:0] idx);
        return 24'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle. master = sequencer side,
// slave = datapath side.
interface control_sequencer_if;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [23:0] Rin;
    logic [23:0] Rout;
    logic        IRin;
    logic        MARin;
    logic        MDRread;
    logic        RYin;
    logic        RZin;
    logic        IncPC;
    logic [4:0]  alu_op;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  run, mem_ready, ir,
        output Rin, Rout, IRin, MARin, MDRread, RYin, RZin, IncPC,
               alu_op, halted, state
    );

    modport slave (
        output run, mem_ready, ir,
        input  Rin, Rout, IRin, MARin, MDRread, RYin, RZin, IncPC,
               alu_op, halted, state
    );
endinterface

// File: rtl/ctrl_decode.sv
// Instruction field decode: op class and register indices from the IR.
// Macro CTRL_SEQ_MULDIV_EN enables the mul/div class; otherwise they decode as nop.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:15] ir_hi,
    output op_class_e    op_class,
    output logic [4:0]   opcode,
    output logic [3:0]   ra,
    output logic [3:0]   rb,
    output logic [3:0]   rc
);

    always_comb begin
        opcode   = ir_hi[31:27];
        ra       = ir_hi[26:23];
        rb       = ir_hi[22:19];
        rc       = ir_hi[18:15];
        // Anything not recognised below executes as a nop.
        op_class = CLS_NOP;
        if (opcode <= OP_RTYPE_MAX) begin
            op_class = CLS_RTYPE;
        end else if (opcode == OP_ADDI) begin
            op_class = CLS_IMM;
        end else if (opcode == OP_HALT) begin
            op_class = CLS_HALT;
        end
`ifdef CTRL_SEQ_MULDIV_EN
        else if (opcode == OP_MUL || opcode == OP_DIV) begin
            op_class = CLS_MULDIV;
        end
`endif
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2), decode/execute (T3-T6), HALT.
// Macro CTRL_SEQ_MULDIV_EN enables the mul/div path through T6.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic                       clock,
    input  logic                       clear,
    control_sequencer_if.master        bus
);

    state_e     state_q, state_d;
    logic       t1_first_q, t1_first_d;
    op_class_e  op_class;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_low;

    assign unused_ir_low = ^bus.ir[14:0];

    ctrl_decode u_decode (
        .ir_hi    (bus.ir[31:15]),
        .op_class (op_class),
        .opcode   (opcode),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc)
    );

    // NOTE: sequential state uses non-blocking assignments; clear is synchronous.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            t1_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_first_q <= t1_first_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        // T1 is only ever entered from T0, so this marks its first cycle.
        t1_first_d = (state_q == S_T0);
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (op_class)
                    CLS_HALT: state_d = S_HALT;
                    CLS_NOP:  state_d = S_T0;
                    default:  state_d = S_T4;
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (op_class == CLS_MULDIV) state_d = S_T6;
                else                        state_d = bus.run ? S_T0 : S_IDLE;
            end
            S_T6:   state_d = bus.run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        bus.Rin     = '0;
        bus.Rout    = '0;
        bus.IRin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRread = 1'b0;
        bus.RYin    = 1'b0;
        bus.RZin    = 1'b0;
        bus.IncPC   = 1'b0;
        bus.alu_op  = '0;
        bus.halted  = 1'b0;
        case (state_q)
            S_T0: begin
                bus.Rout  = onehot(IDX_PC);
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.RZin  = 1'b1;
            end
            S_T1: begin
                bus.Rout    = onehot(IDX_ZLOW);
                bus.MDRread = 1'b1;
                // PC load wins the first T1 cycle so Rin stays one-hot;
                // the MDR load enable covers the remaining wait cycles.
                bus.Rin     = t1_first_q ? onehot(IDX_PC) : onehot(IDX_MDR);
            end
            S_T2: begin
                bus.Rout = onehot(IDX_MDR);
                bus.IRin = 1'b1;
            end
            S_T3: begin
                if (op_class inside {CLS_RTYPE, CLS_IMM, CLS_MULDIV}) begin
                    bus.Rout = onehot({1'b0, rb});
                    bus.RYin = 1'b1;
                end
            end
            S_T4: begin
                bus.alu_op = opcode;
                bus.RZin   = 1'b1;
                case (op_class)
                    CLS_RTYPE:  bus.Rout = onehot({1'b0, rc});
                    CLS_IMM:    bus.Rout = onehot(IDX_C);
                    CLS_MULDIV: bus.Rout = onehot({1'b0, ra});
                    default:    bus.Rout = '0;
                endcase
            end
            S_T5: begin
                bus.Rout = onehot(IDX_ZLOW);
                bus.Rin  = (op_class == CLS_MULDIV) ? onehot(IDX_LO) : onehot({1'b0, ra});
            end
            S_T6: begin
                bus.Rout = onehot(IDX_ZHIGH);
                bus.Rin  = onehot(IDX_HI);
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: drivers push per-cycle expected
// records built from an instruction-level model; a negedge monitor pops and compares.
module tb_control_sequencer;

    typedef struct packed {
        logic [3:0]  st;
        logic [23:0] rin;
        logic [23:0] rout;
        logic [5:0]  strb;   // {IRin, MARin, MDRread, RYin, RZin, IncPC}
        logic [4:0]  alu;
        logic        halted;
    } rec_t;

    localparam logic [5:0] S_IR  = 6'b100000;
    localparam logic [5:0] S_MAR = 6'b010000;
    localparam logic [5:0] S_MDR = 6'b001000;
    localparam logic [5:0] S_RY  = 6'b000100;
    localparam logic [5:0] S_RZ  = 6'b000010;
    localparam logic [5:0] S_INC = 6'b000001;

`ifdef CTRL_SEQ_MULDIV_EN
    localparam bit MULDIV_ON = 1'b1;
`else
    localparam bit MULDIV_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic mon_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rec_t exp_q[$];

    always #5 clock = ~clock;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input int st, input int rin_i, input int rout_i,
                                input logic [5:0] strb, input logic [4:0] alu, input logic h);
        rec_t r;
        r.st     = 4'(st);
        r.rin    = (rin_i < 0) ? 24'd0 : (24'd1 << rin_i);
        r.rout   = (rout_i < 0) ? 24'd0 : (24'd1 << rout_i);
        r.strb   = strb;
        r.alu    = alu;
        r.halted = h;
        return r;
    endfunction

    // 0 R-type, 1 addi, 2 mul/div, 3 nop (incl. undefined), 4 halt
    function automatic int op_cls(input logic [31:0] ir);
        int op;
        op = int'(ir[31:27]);
        if (op <= 7) return 0;
        if (op == 8) return 1;
        if (MULDIV_ON && (op == 15 || op == 16)) return 2;
        if (op == 27) return 4;
        return 3;
    endfunction

    // Expected per-cycle trace of one instruction, starting at its T0 cycle.
    task automatic push_instr(input logic [31:0] ir, input int waits, output int n);
        int c, ra, rb, rc;
        c  = op_cls(ir);
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        exp_q.push_back(mk(1, -1, 20, S_MAR | S_RZ | S_INC, 5'd0, 1'b0));
        for (int i = 0; i <= waits; i++)
            exp_q.push_back(mk(2, (i == 0) ? 20 : 21, 19, S_MDR, 5'd0, 1'b0));
        exp_q.push_back(mk(3, -1, 21, S_IR, 5'd0, 1'b0));
        n = 4 + waits;
        if (c <= 2) begin
            exp_q.push_back(mk(4, -1, rb, S_RY, 5'd0, 1'b0));
            exp_q.push_back(mk(5, -1, (c == 0) ? rc : (c == 1) ? 23 : ra, S_RZ, ir[31:27], 1'b0));
            exp_q.push_back(mk(6, (c == 2) ? 17 : ra, 19, 6'd0, 5'd0, 1'b0));
            n += 2;
            if (c == 2) begin
                exp_q.push_back(mk(7, 16, 18, 6'd0, 5'd0, 1'b0));
                n += 1;
            end
        end else begin
            exp_q.push_back(mk(4, -1, -1, 6'd0, 5'd0, 1'b0));
        end
    endtask

    // next_kind: 0 -> continues in T0, 1 -> goes IDLE, 2 -> goes HALT
    task automatic issue(input logic [31:0] ir, input int waits, input logic run_next,
                         output int next_kind);
        int n, c;
        c = op_cls(ir);
        push_instr(ir, waits, n);
        bus.ir  = ir;
        bus.run = run_next;
        for (int k = 0; k < n; k++) begin
            if (k >= 1 && k <= waits + 1) bus.mem_ready = (k - 1 >= waits);
            else                          bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        if (c == 4)      next_kind = 2;
        else if (c == 3) next_kind = 0;
        else             next_kind = run_next ? 0 : 1;
    endtask

    task automatic idle_for(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mk(0, -1, -1, 6'd0, 5'd0, 1'b0));
            bus.run       = (k == n - 1);
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
    endtask

    task automatic halt_phase(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(mk(8, -1, -1, 6'd0, 5'd0, 1'b1));
            bus.run = k[0];
            clear   = (k == n - 1);
            @(posedge clock); #1;
        end
        clear = 1'b0;
    endtask

    task automatic clear_in_t1();
        exp_q.push_back(mk(1, -1, 20, S_MAR | S_RZ | S_INC, 5'd0, 1'b0));
        exp_q.push_back(mk(2, 20, 19, S_MDR, 5'd0, 1'b0));
        bus.ir = 32'h01110000; bus.run = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            rec_t act;
            act.st     = bus.state;
            act.rin    = bus.Rin;
            act.rout   = bus.Rout;
            act.strb   = {bus.IRin, bus.MARin, bus.MDRread, bus.RYin, bus.RZin, bus.IncPC};
            act.alu    = bus.alu_op;
            act.halted = bus.halted;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL trace_underflow: cycle %0d got %h expected no output", cyc, act);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                check($sformatf("cycle%0d_state%0d", cyc, e.st), act, e);
            end
            check("rin_onehot", 64'($countones(bus.Rin) <= 1), 64'd1);
            check("rout_onehot", 64'($countones(bus.Rout) <= 1), 64'd1);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nk;
        logic [31:0] rnd;
        logic [4:0] op;
        int waits;
        logic rn;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
        @(posedge clock); #1;
        clear  = 1'b0;
        mon_en = 1'b1;

        idle_for(2);
        issue(32'h01110000, 0, 1'b1, nk);   // add R2,R2,R2
        issue(32'h01110000, 3, 1'b0, nk);   // wait states in T1, then IDLE
        idle_for(1);
        issue(32'h7A100000, 1, 1'b1, nk);   // mul R4,R2
        clear_in_t1();
        idle_for(1);
        issue(32'h40A00000, 0, 1'b1, nk);   // addi
        issue(32'hF0000000, 2, 1'b1, nk);   // undefined opcode -> nop
        issue(32'hD8000000, 0, 1'b1, nk);   // halt
        halt_phase(5);
        idle_for(1);

        for (int i = 0; i < 45; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 1) == 0) op = 5'($urandom_range(0, 31));
            else begin
                case ($urandom_range(0, 3))
                    0: op = 5'($urandom_range(0, 7));
                    1: op = 5'd8;
                    2: op = 5'd15;
                    default: op = 5'd16;
                endcase
            end
            if (op == 5'd27) op = 5'd26;
            waits = $urandom_range(0, 3);
            rn    = ($urandom_range(0, 3) != 0);
            issue({op, rnd[26:0]}, waits, rn, nk);
            if (nk == 1) idle_for($urandom_range(1, 3));
        end

        mon_en = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: clear  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: run  in  1  level; 1 permits leaving IDLE and HALT.
REQ-004 SHALL have ports: mem_ready  in  1  memory read data valid on Mdatain.
REQ-005 SHALL have ports: ir  in  32  IR contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-006 SHALL have ports: Rin  out  24  one-hot register load enables; 0-15 R0-R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C.
REQ-007 SHALL have ports: Rout  out  24  one-hot bus-drive selects, same index map as Rin.
REQ-008 SHALL have ports: IRin, MARin, MDRread, RYin, RZin  out  1 each  datapath strobes.
REQ-009 SHALL have ports: IncPC  out  1  forces ALU to BusMuxOut+1.
REQ-010 SHALL have ports: alu_op  out  5  ALU operation, equals ir opcode in T4.
REQ-011 SHALL have ports: halted  out  1  high while in HALT.
REQ-012 SHALL have ports: state  out  4  current state encoding, for debug.

Function
REQ-013 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; all outputs are Moore decodes of state and ir.
REQ-014 IDLE: all strobes 0; run=1 -> T0 next edge.
REQ-015 T0: Rout[20], MARin, IncPC, RZin; -> T1.
REQ-016 T1: Rout[19], Rin[20], MDRread, Rin[21]; stays in T1 while mem_ready=0, with Rin[20] asserted only on the first T1 cycle; -> T2 when mem_ready=1.
REQ-017 T2: Rout[21], IRin; -> T3.
REQ-018 T3: decode ir; opcode 11011 (halt) -> HALT with no strobes; opcode 11010 (nop) -> T0 with no strobes; else Rout[Rb], RYin; -> T4.
REQ-019 T4: Rout[Rc] for R-type (opcodes 00000-00111), Rout[23] for addi (01000); alu_op=opcode; RZin; -> T5.
REQ-020 T5: Rout[19], Rin[Ra]; mul (01111)/div (10000) target Rin[17] instead; -> T6 if mul/div, else T0 (run=1) or IDLE (run=0).
REQ-021 T6: Rout[18], Rin[16]; -> T0 (run=1) or IDLE (run=0).
REQ-022 Undefined opcode in T3 SHALL behave as nop.
REQ-023 HALT: halted=1, all strobes 0; leaves only on clear; run ignored.
REQ-024 Rin and Rout SHALL never have more than one bit set in any cycle.
REQ-025 Register index 0 on Rin SHALL still be driven (no R0 write suppression).

Reset
REQ-026 clear=1 at an edge SHALL force IDLE regardless of state, including mid-fetch in T1; all outputs 0 the following cycle.
REQ-027 Reset values: Rin=0, Rout=0, all 1-bit outputs 0, alu_op=0, state=IDLE encoding 0.

Configuration
REQ-028 With macro CTRL_SEQ_MULDIV_EN defined, mul/div SHALL follow REQ-020/021; undefined, opcodes 01111/10000 SHALL decode as nop and T6 SHALL be unreachable.

Structure
REQ-029 Package ctrl_pkg SHALL hold the state enum, opcode constants, and Rin/Rout index constants (IDX_HI=16 ... IDX_C=23).
REQ-030 Combinational sub-module ctrl_decode SHALL map ir to op class (RTYPE, IMM, MULDIV, NOP, HALT) and register indices.

Verification
REQ-031 clear, run=1, mem_ready=1, ir=0x01110000 (add R2,R2,R2): trace IDLE,T0..T5,T0; T5 shows Rin=0x000004, Rout=0x080000.
REQ-032 mem_ready held 0 for 3 cycles in T1: T1 lasts 4 cycles; Rin[20] high only in the first.
REQ-033 ir=0xD8000000 (halt): T3 -> HALT; halted=1 persists with run toggled; clear returns IDLE.
REQ-034 ir=0x7A100000 (mul R4,R2) with macro defined: T5 Rin=0x020000, T6 Rin=0x010000 and Rout=0x040000; without macro: T3 -> T0.
REQ-035 clear asserted during T1: next cycle state=0 and all outputs 0.
REQ-036 Every cycle of a 200-cycle random-opcode run: popcount(Rin)<=1 and popcount(Rout)<=1.
